encoder_8_3_event: RTL and testbench

//  Event-capturing 8-to-3 encoder: turns rising edges on 8 independent request lines into a stream of
//  3-bit codes (code i <=> line i) delivered over a valid/ready handshake. Inverse of the team's 3-8 decoder;

---
 rtl/encoder_pkg.sv | 28 ++
 rtl/enc_prio_sel.sv | 50 +++++
 rtl/encoder_8_3_event.sv | 109 ++++++++++
 tb/tb_encoder_8_3_event.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the event-capturing 8-to-3 encoder.
//   DEF_N_IN / DEF_CODE_W : default number of request lines and code width
//   clog2()               : ceiling log2, used to derive the code width
//   state_t               : output-register state (EMPTY = no code, HOLD = code presented)
//   onehot()              : index-to-one-hot helper, up to MAX_N_IN lines
package encoder_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int DEF_N_IN   = 8;
  localparam int DEF_CODE_W = clog2(DEF_N_IN);
  localparam int MAX_N_IN   = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic logic [MAX_N_IN-1:0] onehot(input int unsigned idx);
    return MAX_N_IN'(1) << idx;
  endfunction

endpackage

// File: rtl/enc_prio_sel.sv
// Combinational selector: picks one index out of the candidate vector.
//   cand : candidate events (pending | new rising edges)
//   ptr  : index granted last (round-robin build only)
//   sel  : chosen index, valid when any = 1
//   any  : at least one candidate is set
// Build option: RR_ARB_EN defined -> round-robin search starting at ptr+1;
// undefined -> fixed priority, highest index wins, ptr ignored.
module enc_prio_sel
  import encoder_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic [N_IN-1:0]   cand,
  input  logic [CODE_W-1:0] ptr,
  output logic [CODE_W-1:0] sel,
  output logic              any
);

  assign any = |cand;

`ifdef RR_ARB_EN
  always_comb begin : rr_search
    logic found;
    // NOTE: every output of a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    sel   = '0;
    found = 1'b0;
    // Walk upward from the slot after the last grant, wrapping at N_IN.
    for (int k = 1; k <= N_IN; k++) begin
      if (!found && cand[(int'(ptr) + k) % N_IN]) begin
        sel   = CODE_W'((int'(ptr) + k) % N_IN);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin : fixed_search
    sel = '0;
    // Later iterations overwrite earlier ones, so the highest set index wins.
    for (int k = 0; k < N_IN; k++) begin
      if (cand[k]) sel = CODE_W'(k);
    end
  end

  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/encoder_8_3_event.sv
// Event-capturing 8-to-3 encoder. Rising edges on req_in are captured as
// events and delivered one per transfer as a code over a valid/ready pair.
//   Clk        : system clock, rising edge
//   Rst        : synchronous reset, active-high
//   req_in     : request lines; each 0->1 transition is one event
//   code_out   : index of the presented event (stable while stalled)
//   code_valid : code_out holds an unconsumed event
//   code_ready : consumer accepts; transfer = code_valid && code_ready
//   pending    : events captured but not yet presented
//   overflow   : one-cycle pulse when an event merges into a pending one
// Build option: RR_ARB_EN selects round-robin instead of fixed
// highest-index priority; ports and latency are the same in both builds.
module encoder_8_3_event
  import encoder_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_IN-1:0]   req_in,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [N_IN-1:0]   pending,
  output logic              overflow
);

  state_t              state_q, state_d;
  logic [N_IN-1:0]     req_q;
  logic [N_IN-1:0]     rise;
  logic [N_IN-1:0]     cand;
  logic [N_IN-1:0]     pending_d;
  logic [CODE_W-1:0]   code_d;
  logic [CODE_W-1:0]   sel;
  logic [CODE_W-1:0]   ptr;
  logic                any;
  logic                load_en;
  logic                load;

  assign rise       = req_in & ~req_q;
  assign cand       = pending | rise;
  assign code_valid = (state_q == HOLD);

  enc_prio_sel #(
    .N_IN   (N_IN),
    .CODE_W (CODE_W)
  ) u_sel (
    .cand (cand),
    .ptr  (ptr),
    .sel  (sel),
    .any  (any)
  );

  // Output register may take a new code when empty or when the current one
  // is being consumed this cycle. A chosen event leaves pending as soon as
  // it is presented, so a new edge on the presented line re-enters pending
  // cleanly and does not count as overflow.
  always_comb begin
    state_d   = state_q;
    code_d    = code_out;
    pending_d = cand;
    load_en   = (state_q == EMPTY) || code_ready;
    load      = 1'b0;
    if (load_en) begin
      if (any) begin
        load      = 1'b1;
        state_d   = HOLD;
        code_d    = sel;
        pending_d = cand & ~N_IN'(onehot(int'(sel)));
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= EMPTY;
      code_out <= '0;
      pending  <= '0;
      req_q    <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_out <= code_d;
      pending  <= pending_d;
      req_q    <= req_in;
      overflow <= |(rise & pending);
    end
  end

`ifdef RR_ARB_EN
  // Pointer to the last granted index; reset to N_IN-1 so index 0 is
  // favoured by the first search.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr <= CODE_W'(N_IN - 1);
    end else if (load) begin
      ptr <= sel;
    end
  end
`else
  assign ptr = CODE_W'(N_IN - 1);
`endif

endmodule

// File: tb/tb_encoder_8_3_event.sv
// Directed self-checking bench for encoder_8_3_event. Expectations depend on
// RR_ARB_EN so the same bench covers both selector builds.
module tb_encoder_8_3_event;

  logic       Clk;
  logic       Rst;
  logic [7:0] req_in;
  logic [2:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] pending;
  logic       overflow;

  int n_assert;
  int n_fail;

`ifdef RR_ARB_EN
  localparam logic [2:0] T2_A = 3'd0, T2_B = 3'd7;
  localparam logic [2:0] T3_A = 3'd3, T3_B = 3'd5;
  localparam logic [2:0] T6_C0 = 3'd0, T6_C1 = 3'd1, T6_C2 = 3'd2;
  localparam logic [2:0] T6_TAIL [7] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
`else
  localparam logic [2:0] T2_A = 3'd7, T2_B = 3'd0;
  localparam logic [2:0] T3_A = 3'd5, T3_B = 3'd3;
  localparam logic [2:0] T6_C0 = 3'd7, T6_C1 = 3'd6, T6_C2 = 3'd7;
  localparam logic [2:0] T6_TAIL [7] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
`endif

  encoder_8_3_event dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .req_in     (req_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pending    (pending),
    .overflow   (overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step();
    step();
    Rst = 1'b0;
  endtask

  task automatic expect_code(input string tag, input logic [2:0] code);
    check({tag, "_valid"}, 32'(code_valid), 32'd1);
    check({tag, "_code"},  32'(code_out),   32'(code));
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    Rst        = 1'b1;
    req_in     = 8'h00;
    code_ready = 1'b0;
    step();
    step();
    check("rst_valid",    32'(code_valid), 32'd0);
    check("rst_code",     32'(code_out),   32'd0);
    check("rst_pending",  32'(pending),    32'h00);
    check("rst_overflow", 32'(overflow),   32'd0);
    Rst = 1'b0;

    // 1: single event, held line must not repeat
    code_ready = 1'b1;
    step();
    req_in = 8'h04;
    step();
    expect_code("t1", 3'd2);
    check("t1_pending", 32'(pending), 32'h00);
    step();
    check("t1_once", 32'(code_valid), 32'd0);
    step();
    check("t1_held", 32'(code_valid), 32'd0);
    req_in = 8'h00;
    step();

    // 2: simultaneous edges, presented over consecutive transfers
    do_reset();
    req_in = 8'h81;
    step();
    expect_code("t2_first", T2_A);
    check("t2_pend_a", 32'(pending), 32'(8'h81 & ~(8'h01 << T2_A)));
    req_in = 8'h00;
    step();
    expect_code("t2_second", T2_B);
    check("t2_pend_b", 32'(pending), 32'h00);
    step();
    check("t2_drained", 32'(code_valid), 32'd0);

    // 3: back-pressure accumulates, release drains one per cycle
    code_ready = 1'b0;
    req_in     = 8'h02;
    step();
    expect_code("t3_first", 3'd1);
    req_in = 8'h08;
    step();
    check("t3_hold_a", 32'(code_out), 32'd1);
    check("t3_pend_a", 32'(pending),  32'h08);
    req_in = 8'h20;
    step();
    check("t3_hold_b", 32'(code_out), 32'd1);
    check("t3_pend_b", 32'(pending),  32'h28);
    req_in = 8'h00;
    step();
    expect_code("t3_stall", 3'd1);
    code_ready = 1'b1;
    step();
    expect_code("t3_rest_a", T3_A);
    step();
    expect_code("t3_rest_b", T3_B);
    check("t3_pend_end", 32'(pending), 32'h00);
    step();
    check("t3_drained", 32'(code_valid), 32'd0);

    // 4: overflow merges two events on line 6
    code_ready = 1'b0;
    req_in     = 8'h01;
    step();
    expect_code("t4_occupy", 3'd0);
    req_in = 8'h40;
    step();
    check("t4_pend",  32'(pending),  32'h40);
    check("t4_no_ov", 32'(overflow), 32'd0);
    req_in = 8'h00;
    step();
    req_in = 8'h40;
    step();
    check("t4_ov",      32'(overflow), 32'd1);
    check("t4_pend_ov", 32'(pending),  32'h40);
    req_in = 8'h00;
    step();
    check("t4_ov_pulse", 32'(overflow), 32'd0);
    code_ready = 1'b1;
    step();
    expect_code("t4_six", 3'd6);
    step();
    check("t4_single", 32'(code_valid), 32'd0);

    // 5: reset mid-operation with a line held high through reset
    code_ready = 1'b0;
    req_in     = 8'h01;
    step();
    req_in = 8'h0C;
    step();
    expect_code("t5_pre", 3'd0);
    check("t5_pre_pend", 32'(pending), 32'h0C);
    req_in = 8'h08;
    Rst    = 1'b1;
    step();
    check("t5_rst_valid", 32'(code_valid), 32'd0);
    check("t5_rst_code",  32'(code_out),   32'd0);
    check("t5_rst_pend",  32'(pending),    32'h00);
    check("t5_rst_ov",    32'(overflow),   32'd0);
    step();
    Rst        = 1'b0;
    code_ready = 1'b1;
    step();
    expect_code("t5_after", 3'd3);
    step();
    check("t5_once_a", 32'(code_valid), 32'd0);
    step();
    check("t5_once_b", 32'(code_valid), 32'd0);
    req_in = 8'h00;

    // 6: repeated 0xFF bursts with ready held high
    do_reset();
    req_in = 8'hFF;
    step();
    expect_code("t6_c0", T6_C0);
    check("t6_ov0", 32'(overflow), 32'd0);
    req_in = 8'h00;
    step();
    expect_code("t6_c1", T6_C1);
    req_in = 8'hFF;
    step();
    expect_code("t6_c2", T6_C2);
    check("t6_ov1", 32'(overflow), 32'd1);
    req_in = 8'h00;
    for (int i = 0; i < 7; i++) begin
      step();
      expect_code($sformatf("t6_tail%0d", i), T6_TAIL[i]);
      check($sformatf("t6_ov_tail%0d", i), 32'(overflow), 32'd0);
    end
    step();
    check("t6_drained", 32'(code_valid), 32'd0);
    check("t6_pend_end", 32'(pending), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
